// File: rtl/loader_pkg.sv
// loader_pkg: shared state, write-entry type and region decode for the ioctl SDRAM loader
package loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ds;
  } wr_entry_t;
  function automatic logic [32:0] region_hit(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] size);
    logic [31:0] off;
    off = addr - base;
    return {size != 0 && addr >= base && off < size, off};
  endfunction
endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// ioctl_sdram_loader_if: data_io byte stream in, SDRAM req/ack write port out
interface ioctl_sdram_loader_if #(
  parameter int IOCTL_AW = 25,
  parameter int RAM_AW = 22,
  parameter int WORD_BYTES = 2
);
  logic ioctl_download;
  logic [7:0] ioctl_index;
  logic ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic ram_req;
  logic ram_ack;
  logic [RAM_AW-1:0] ram_addr;
  logic [8*WORD_BYTES-1:0] ram_din;
  logic [WORD_BYTES-1:0] ram_ds;
  logic ram_we;
  modport master (
    input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
    output ram_req, ram_addr, ram_din, ram_ds, ram_we
  );
  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
    input ram_req, ram_addr, ram_din, ram_ds, ram_we
  );
endinterface

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO of pending SDRAM write entries; pushes while full are ignored
module loader_fifo import loader_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  wr_entry_t mem [DEPTH];
  logic [PW:0] wp, rp;
  assign full = wp[PW] != rp[PW] && wp[PW-1:0] == rp[PW-1:0];
  assign empty = wp == rp;
  assign dout = mem[rp[PW-1:0]];
  // storage write
  always_ff @(posedge clk_sys) begin
    if (push && !full) mem[wp[PW-1:0]] <= din;
  end
  // read/write pointers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: region-filtered byte packer feeding SDRAM writes, plus rom_loaded/core reset (optional LOADER_CHECKSUM_EN adds checksum output)
module ioctl_sdram_loader import loader_pkg::*; #(
  parameter int IOCTL_AW = 25,
  parameter int RAM_AW = 22,
  parameter int WORD_BYTES = 2,
  parameter int NREG = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX = 8'h00,
  parameter int RESET_HOLD = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  ioctl_sdram_loader_if.master bus,
  input  logic [NREG*IOCTL_AW-1:0] reg_base,
  input  logic [NREG*IOCTL_AW-1:0] reg_size,
  input  logic [NREG*RAM_AW-1:0] reg_dst,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic busy,
  output logic overflow,
  output logic rom_loaded,
  output logic core_reset_n
);
  localparam int SH = $clog2(WORD_BYTES);
  localparam int DW = 8*WORD_BYTES;
  localparam int HW = $clog2(RESET_HOLD+1);
  state_t state, next;
  logic wr_d, dl_rom, ev, take, hit, match, flush, old, push, pk_valid, pk_full;
  logic fifo_full, fifo_empty, pop, issue, inflight, idle_ack;
  logic [32:0] rh;
  logic [RAM_AW-1:0] word, pk_addr;
  logic [SH-1:0] lane;
  logic [DW-1:0] pk_data, new_data;
  logic [WORD_BYTES-1:0] pk_ds, new_ds;
  logic [HW-1:0] hold;
  wr_entry_t push_e, head;
  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys(clk_sys), .reset_n(reset_n), .push(push), .din(push_e), .pop(pop),
    .dout(head), .full(fifo_full), .empty(fifo_empty)
  );
  // region decode: iterate downwards so the lowest-numbered hit wins
  always_comb begin
    hit = 1'b0;
    word = '0;
    lane = '0;
    rh = '0;
    for (int r = NREG-1; r >= 0; r--) begin
      rh = region_hit(32'(bus.ioctl_addr), 32'(reg_base[r*IOCTL_AW +: IOCTL_AW]), 32'(reg_size[r*IOCTL_AW +: IOCTL_AW]));
      if (rh[32]) begin
        hit = 1'b1;
        word = reg_dst[r*RAM_AW +: RAM_AW] + RAM_AW'(rh[31:0] >> SH);
        lane = rh[SH-1:0];
      end
    end
  end
  // packer merge and FIFO push selection; an old partial word always takes priority over the new byte
  always_comb begin
    dl_rom = bus.ioctl_download && bus.ioctl_index == ROM_INDEX;
    ev = state == LOAD && bus.ioctl_wr && !wr_d;
    take = ev && hit;
    match = pk_valid && pk_addr == word;
    new_ds = (match ? pk_ds : '0) | (WORD_BYTES'(1) << lane);
    new_data = ((match ? pk_data : '0) & ~(DW'(8'hFF) << (8*lane))) | (DW'(bus.ioctl_dout) << (8*lane));
    pk_full = &new_ds;
    flush = state == DRAIN && pk_valid;
    old = flush || (pk_valid && !match);
    push = flush || (take && (old || pk_full));
    push_e = '0;
    push_e.addr = 32'(old ? pk_addr : word);
    push_e.data = 32'(old ? pk_data : new_data);
    push_e.ds = 4'(old ? pk_ds : new_ds);
    idle_ack = bus.ram_ack == bus.ram_req;
    pop = inflight && idle_ack;
    issue = !inflight && !fifo_empty && idle_ack;
  end
  // partial-word register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pk_valid <= 1'b0;
      pk_addr <= '0;
      pk_data <= '0;
      pk_ds <= '0;
    end else if (flush) begin
      pk_valid <= 1'b0;
    end else if (take) begin
      pk_valid <= !pk_full;
      pk_addr <= word;
      pk_data <= new_data;
      pk_ds <= new_ds;
    end
  end
  // RAM port: present the head and toggle req together; the head is popped once ack catches up
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.ram_req <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din <= '0;
      bus.ram_ds <= '0;
      inflight <= 1'b0;
    end else if (issue) begin
      bus.ram_req <= ~bus.ram_req;
      bus.ram_addr <= RAM_AW'(head.addr);
      bus.ram_din <= DW'(head.data);
      bus.ram_ds <= WORD_BYTES'(head.ds);
      inflight <= 1'b1;
    end else if (pop) begin
      inflight <= 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else state <= next;
  end
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE: next = dl_rom ? LOAD : IDLE;
      LOAD: next = bus.ioctl_download ? LOAD : DRAIN;
      DRAIN: next = !pk_valid && fifo_empty && !inflight && idle_ack ? DONE : DRAIN;
      DONE: next = dl_rom ? LOAD : hold == HW'(RESET_HOLD-1) ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  // state-decoded outputs; the core is released only in IDLE after a completed download
  always_comb begin
    busy = state == LOAD || state == DRAIN;
    bus.ram_we = busy;
    core_reset_n = state == IDLE && rom_loaded;
  end
  // edge detect, reset hold counter and sticky status
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_d <= 1'b0;
      hold <= '0;
      overflow <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_d <= bus.ioctl_wr;
      hold <= state == DONE ? hold + 1'b1 : '0;
      overflow <= state == IDLE && next == LOAD ? 1'b0 : overflow | (push && fifo_full);
      rom_loaded <= rom_loaded | (state == DRAIN && next == DONE);
    end
  end
`ifdef LOADER_CHECKSUM_EN
  // wrapping sum of every accepted byte of the current download
  always_ff @(posedge clk_sys) begin
    if (!reset_n) checksum <= '0;
    else if (state == IDLE && next == LOAD) checksum <= '0;
    else if (take) checksum <= checksum + 16'(bus.ioctl_dout);
  end
`endif
endmodule
